axis_rr_packet_arbiter: RTL

AXIS_RR_PACKET_ARBITER -- requirements
Module: axis_rr_packet_arbiter

---
 rtl/axis_rr_packet_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/axis_rr_packet_arbiter.sv
// Round-robin AXI-Stream packet arbiter: N_INPUTS sources share one output stream,
// and the grant is held from the first beat of a packet through its TLAST handshake.
module axis_rr_packet_arbiter #(
    parameter int N_INPUTS        = 5,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int IDX_WIDTH       = $clog2(N_INPUTS)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [N_INPUTS-1:0]                 s_tvalid_i,
    input  logic [N_INPUTS*AXIS_DATA_WIDTH-1:0] s_tdata_i,
    input  logic [N_INPUTS-1:0]                 s_tlast_i,
    output logic [N_INPUTS-1:0]                 s_tready_o,
    output logic                                m_tvalid_o,
    output logic [AXIS_DATA_WIDTH-1:0]          m_tdata_o,
    output logic                                m_tlast_o,
    input  logic                                m_tready_i,
    output logic [IDX_WIDTH-1:0]                grant_idx_o,
    output logic                                busy_o,
    output logic [15:0]                         pkt_cnt_o
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                       state_r;
    logic [IDX_WIDTH-1:0]         rr_ptr_r;
    logic [IDX_WIDTH-1:0]         grant_r;
    logic                         busy_r;
    logic [15:0]                  pkt_cnt_r;

    logic                         pick_found_s;
    logic [IDX_WIDTH-1:0]         pick_idx_s;
    logic [IDX_WIDTH-1:0]         cand_s;
    logic [IDX_WIDTH-1:0]         next_ptr_s;
    logic                         locked_s;
    logic                         g_tvalid_s;
    logic                         g_tlast_s;
    logic [AXIS_DATA_WIDTH-1:0]   g_tdata_s;
    logic                         tlast_hs_s;

    // Index increment that wraps at the last input rather than at a power of two.
    function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] idx);
        logic [IDX_WIDTH-1:0] res;
        if (idx == IDX_WIDTH'(N_INPUTS - 1)) begin
            res = {IDX_WIDTH{1'b0}};
        end else begin
            res = idx + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    assign locked_s   = (state_r == ST_LOCKED);
    assign next_ptr_s = wrap_inc(grant_r);

    // First requesting input found walking upward from rr_ptr_r, wrapping to 0.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = {IDX_WIDTH{1'b0}};
        cand_s       = rr_ptr_r;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (!pick_found_s && s_tvalid_i[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
            cand_s = wrap_inc(cand_s);
        end
    end

    // Select the granted input's sideband signals.
    always_comb begin
        g_tvalid_s = s_tvalid_i[grant_r];
        g_tlast_s  = s_tlast_i[grant_r];
        g_tdata_s  = s_tdata_i[int'(grant_r)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    end

    assign tlast_hs_s = locked_s & g_tvalid_s & m_tready_i & g_tlast_s;

    // Output stream follows the owner only while locked; everything is quiet in IDLE.
    always_comb begin
        m_tvalid_o = 1'b0;
        m_tlast_o  = 1'b0;
        m_tdata_o  = {AXIS_DATA_WIDTH{1'b0}};
        s_tready_o = {N_INPUTS{1'b0}};
        if (locked_s) begin
            m_tvalid_o          = g_tvalid_s;
            m_tlast_o           = g_tlast_s;
            m_tdata_o           = g_tdata_s;
            s_tready_o[grant_r] = m_tready_i;
        end else begin
            m_tvalid_o = 1'b0;
            s_tready_o = {N_INPUTS{1'b0}};
        end
    end

    // Arbitration FSM; the pointer and packet count only move on a TLAST handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            rr_ptr_r  <= {IDX_WIDTH{1'b0}};
            grant_r   <= {IDX_WIDTH{1'b0}};
            busy_r    <= 1'b0;
            pkt_cnt_r <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        grant_r <= pick_idx_s;
                        busy_r  <= 1'b1;
                        state_r <= ST_LOCKED;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (tlast_hs_s) begin
                        rr_ptr_r  <= next_ptr_s;
                        pkt_cnt_r <= pkt_cnt_r + 16'd1;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= ST_LOCKED;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_idx_o = grant_r;
    assign busy_o      = busy_r;
    assign pkt_cnt_o   = pkt_cnt_r;

endmodule
